// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: issues PC to imem, queues {pc, instr} in a small FIFO, feeds decode.
// Optional same-cycle bypass to decode when the FIFO is empty: define INSTR_PREFETCH_BYPASS_EN.
module instr_prefetch #(
    parameter int unsigned AW    = 16,
    parameter int unsigned IW    = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic          CLK,
    input  logic          Init,
    input  logic [AW-1:0] PC,
    input  logic          Halt_in,
    input  logic          Flush,
    output logic [AW-1:0] Imem_addr,
    output logic          Imem_rd,
    input  logic [IW-1:0] Imem_data,
    output logic          Fetch_stall,
    output logic          Dec_valid,
    input  logic          Dec_ready,
    output logic [IW-1:0] Dec_instr,
    output logic [AW-1:0] Dec_pc
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + IW;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          inflight_q;
    logic [AW-1:0] inflight_pc_q;
    logic [EW-1:0] mem_q [DEPTH];

    logic          fifo_nonempty;
    logic          bypass;
    logic          push;
    logic          pop;

    // Handshake, credit and head-of-queue presentation
    always_comb begin
        fifo_nonempty = (count_q != '0);
        Fetch_stall   = (count_q + CW'(inflight_q)) >= CW'(DEPTH);
        Imem_rd       = !Init && !Halt_in && !Flush && !Fetch_stall;
        Imem_addr     = PC;
`ifdef INSTR_PREFETCH_BYPASS_EN
        bypass        = !fifo_nonempty && inflight_q && !Flush;
`else
        bypass        = 1'b0;
`endif
        Dec_valid     = fifo_nonempty || bypass;
        pop           = fifo_nonempty && Dec_ready && !Flush;
        // A bypassed word taken by decode this cycle never enters storage
        push          = inflight_q && !Flush && !(bypass && Dec_ready);

        Dec_pc    = '0;
        Dec_instr = '0;
        if (bypass) begin
            Dec_pc    = inflight_pc_q;
            Dec_instr = Imem_data;
        end else if (fifo_nonempty) begin
            {Dec_pc, Dec_instr} = mem_q[rd_ptr_q];
        end
    end

    // Pointer and occupancy next-state; flush discards everything
    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Init) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= Imem_rd;
            inflight_pc_q <= PC;
        end
    end

    // Payload storage needs no reset; occupancy gates every read
    always_ff @(posedge CLK) begin
        if (!Init && push) begin
            mem_q[wr_ptr_q] <= {inflight_pc_q, Imem_data};
        end
    end

    overflow_a: assert property (@(posedge CLK) disable iff (Init)
        !(push && (count_q == CW'(DEPTH))));

endmodule
